axi4_stream_pkt_limiter: RTL and testbench

Packet-length enforcement stage placed directly upstream of `axi4_stream_fifo` when `SMART=1`. It guarantees that no packet longer than `MAX_WORDS` beats reaches the FIFO. An over-length packet is cut after beat `MAX_WORDS` with `tlast` forced high, and its remaining beats are discarded. The FIFO therefore drops only on real overflow, not on runaway or unterminated packets. The block adds one register stage with full throughput and honours downstream backpressure.

---
 rtl/axi4_stream_pkt_limiter_if.sv | 30 +++
 rtl/axi4_stream_pkt_limiter.sv | 162 ++++++++++++++++
 tb/tb_axi4_stream_pkt_limiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_pkt_limiter_if.sv
// AXI4-Stream bundle shared by the packet limiter and its neighbours.
// The master drives payload and valid; the slave drives ready.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tstrb;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic [DEST_WIDTH-1:0] tdest;
    logic [ID_WIDTH-1:0]   tid;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
        output tready
    );
endinterface

// File: rtl/axi4_stream_pkt_limiter.sv
// Cuts packets longer than MAX_WORDS beats (forcing tlast) and drops their tail.
// Define AXI4_STREAM_PKT_LIMITER_STATS_EN to build the packet/truncation counters.
module axi4_stream_pkt_limiter #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int MAX_WORDS  = 64,
    parameter int CNT_WIDTH  = $clog2(MAX_WORDS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    axi4_stream_if.slave        pkt_i,
    axi4_stream_if.master       pkt_o,
    output logic                truncated_o,
    output logic [31:0]         pkt_cnt_o,
    output logic [31:0]         trunc_cnt_o
);
    localparam int                   KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX   = CNT_WIDTH'(MAX_WORDS - 1);

    typedef enum logic {
        ST_PASS,
        ST_DISCARD
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_wcnt;
    logic [CNT_WIDTH-1:0]  w_wcnt_nxt;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KEEP_WIDTH-1:0] r_tstrb;
    logic [KEEP_WIDTH-1:0] r_tkeep;
    logic                  r_tlast;
    logic [USER_WIDTH-1:0] r_tuser;
    logic [DEST_WIDTH-1:0] r_tdest;
    logic [ID_WIDTH-1:0]   r_tid;
    logic                  r_truncated;

    logic                  w_in_ready;
    logic                  w_acc;
    logic                  w_load;
    logic                  w_at_limit;
    logic                  w_cut;
    logic                  w_out_hs;

    // While discarding, the tail is swallowed regardless of downstream state.
    assign w_in_ready = (r_state == ST_DISCARD) ? 1'b1 : (!r_out_valid || pkt_o.tready);
    assign w_acc      = pkt_i.tvalid && w_in_ready;
    assign w_load     = w_acc && (r_state == ST_PASS);
    assign w_at_limit = (r_wcnt == LAST_IDX);
    assign w_cut      = w_load && !pkt_i.tlast && w_at_limit;
    assign w_out_hs   = r_out_valid && pkt_o.tready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_PASS;
            r_wcnt  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, whatever the block order.
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no branch leaves a variable unassigned and infers a latch.
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        unique case (r_state)
            ST_PASS: begin
                if (w_acc) begin
                    if (pkt_i.tlast) begin
                        w_wcnt_nxt = '0;
                    end else if (w_at_limit) begin
                        w_wcnt_nxt  = '0;
                        w_state_nxt = ST_DISCARD;
                    end else begin
                        w_wcnt_nxt = r_wcnt + CNT_WIDTH'(1);
                    end
                end
            end
            ST_DISCARD: begin
                if (w_acc && pkt_i.tlast) begin
                    w_state_nxt = ST_PASS;
                end
            end
            default: begin
                w_state_nxt = ST_PASS;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: payload is reset too, so downstream sees zeros rather than X before the first beat.
            r_out_valid <= 1'b0;
            r_tdata     <= '0;
            r_tstrb     <= '0;
            r_tkeep     <= '0;
            r_tlast     <= 1'b0;
            r_tuser     <= '0;
            r_tdest     <= '0;
            r_tid       <= '0;
            r_truncated <= 1'b0;
        end else begin
            r_truncated <= w_cut;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_tdata     <= pkt_i.tdata;
                r_tstrb     <= pkt_i.tstrb;
                r_tkeep     <= pkt_i.tkeep;
                r_tlast     <= pkt_i.tlast || w_at_limit;
                r_tuser     <= pkt_i.tuser;
                r_tdest     <= pkt_i.tdest;
                r_tid       <= pkt_i.tid;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign pkt_i.tready = w_in_ready;
    assign pkt_o.tvalid = r_out_valid;
    assign pkt_o.tdata  = r_tdata;
    assign pkt_o.tstrb  = r_tstrb;
    assign pkt_o.tkeep  = r_tkeep;
    assign pkt_o.tlast  = r_tlast;
    assign pkt_o.tuser  = r_tuser;
    assign pkt_o.tdest  = r_tdest;
    assign pkt_o.tid    = r_tid;
    assign truncated_o  = r_truncated;

`ifdef AXI4_STREAM_PKT_LIMITER_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_trunc_cnt;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pkt_cnt   <= '0;
            r_trunc_cnt <= '0;
        end else begin
            if (w_out_hs && r_tlast && (r_pkt_cnt != '1)) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
            if (r_truncated && (r_trunc_cnt != '1)) begin
                r_trunc_cnt <= r_trunc_cnt + 32'd1;
            end
        end
    end

    assign pkt_cnt_o   = r_pkt_cnt;
    assign trunc_cnt_o = r_trunc_cnt;
`else
    assign pkt_cnt_o   = '0;
    assign trunc_cnt_o = '0;
`endif
endmodule

// File: tb/tb_axi4_stream_pkt_limiter.sv
// Directed bench for axi4_stream_pkt_limiter: one instance with MAX_WORDS=4, one with MAX_WORDS=1.
// Counter expectations follow AXI4_STREAM_PKT_LIMITER_STATS_EN (zero when undefined).
module tb_axi4_stream_pkt_limiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        trunc4, trunc1;
    logic [31:0] pkt_cnt4, trunc_cnt4, pkt_cnt1, trunc_cnt1;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_trunc4 = 0;
    int          n_trunc1 = 0;
    logic [32:0] q_out4[$];
    logic [32:0] q_out1[$];

    always #5 clk_i = ~clk_i;

    axi4_stream_if #(.DATA_WIDTH(32)) in4 ();
    axi4_stream_if #(.DATA_WIDTH(32)) out4 ();
    axi4_stream_if #(.DATA_WIDTH(32)) in1 ();
    axi4_stream_if #(.DATA_WIDTH(32)) out1 ();

    axi4_stream_pkt_limiter #(.DATA_WIDTH(32), .MAX_WORDS(4)) u_dut4 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pkt_i       (in4),
        .pkt_o       (out4),
        .truncated_o (trunc4),
        .pkt_cnt_o   (pkt_cnt4),
        .trunc_cnt_o (trunc_cnt4)
    );

    axi4_stream_pkt_limiter #(.DATA_WIDTH(32), .MAX_WORDS(1)) u_dut1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pkt_i       (in1),
        .pkt_o       (out1),
        .truncated_o (trunc1),
        .pkt_cnt_o   (pkt_cnt1),
        .trunc_cnt_o (trunc_cnt1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int v);
`ifdef AXI4_STREAM_PKT_LIMITER_STATS_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    // Accepted output beats and truncation pulses are recorded away from the clock edge.
    always @(negedge clk_i) begin
        if (out4.tvalid && out4.tready) q_out4.push_back({out4.tlast, out4.tdata});
        if (out1.tvalid && out1.tready) q_out1.push_back({out1.tlast, out1.tdata});
        if (trunc4) n_trunc4++;
        if (trunc1) n_trunc1++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send4(input logic [31:0] d, input logic last, input logic [3:0] keep,
                         input bit exp_load, input logic exp_last, input logic exp_trunc,
                         output int waits);
        in4.tdata  = d;
        in4.tlast  = last;
        in4.tkeep  = keep;
        in4.tstrb  = keep;
        in4.tvalid = 1'b1;
        waits = 0;
        @(negedge clk_i);
        while (!in4.tready && waits < 50) begin
            waits++;
            @(negedge clk_i);
        end
        if (!in4.tready) begin
            check("accept_timeout4", in4.tready, 1'b1);
            in4.tvalid = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        in4.tvalid = 1'b0;
        if (exp_load) begin
            check("load_valid4", out4.tvalid, 1'b1);
            check("load_data4", out4.tdata, d);
            check("load_last4", out4.tlast, exp_last);
            check("load_keep4", out4.tkeep, keep);
            check("load_trunc4", trunc4, exp_trunc);
        end
    endtask

    task automatic send1(input logic [31:0] d, input logic last,
                         input bit exp_load, input logic exp_trunc);
        int waits;
        in1.tdata  = d;
        in1.tlast  = last;
        in1.tkeep  = 4'hF;
        in1.tstrb  = 4'hF;
        in1.tvalid = 1'b1;
        waits = 0;
        @(negedge clk_i);
        while (!in1.tready && waits < 50) begin
            waits++;
            @(negedge clk_i);
        end
        if (!in1.tready) begin
            check("accept_timeout1", in1.tready, 1'b1);
            in1.tvalid = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        in1.tvalid = 1'b0;
        if (exp_load) begin
            check("load_data1", out1.tdata, d);
            check("load_last1", out1.tlast, 1'b1);
            check("load_trunc1", trunc1, exp_trunc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        in4.tvalid = 1'b0; in4.tdata = '0; in4.tstrb = '0; in4.tkeep = '0;
        in4.tlast = 1'b0;  in4.tuser = '0; in4.tdest = '0; in4.tid = '0;
        in1.tvalid = 1'b0; in1.tdata = '0; in1.tstrb = '0; in1.tkeep = '0;
        in1.tlast = 1'b0;  in1.tuser = '0; in1.tdest = '0; in1.tid = '0;
        out4.tready = 1'b1;
        out1.tready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_valid4", out4.tvalid, 1'b0);
        check("rst_data4", out4.tdata, 32'h0);
        check("rst_last4", out4.tlast, 1'b0);
        check("rst_trunc4", trunc4, 1'b0);
        check("rst_pktcnt4", pkt_cnt4, 32'h0);
        check("rst_trunccnt4", trunc_cnt4, 32'h0);
        check("rst_valid1", out1.tvalid, 1'b0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        idle(1);

        // Short packet: 3 beats
        q_out4.delete(); n_trunc4 = 0;
        send4(32'hA000_0000, 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        send4(32'hA000_0001, 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        send4(32'hA000_0002, 1'b1, 4'hF, 1, 1'b1, 1'b0, w);
        idle(3);
        check("short_count", q_out4.size(), 3);
        check("short_last", q_out4[2], {1'b1, 32'hA000_0002});
        check("short_notrunc", n_trunc4, 0);
        check("short_pktcnt", pkt_cnt4, stat(1));

        // Exact length: 4 beats
        q_out4.delete(); n_trunc4 = 0;
        for (int i = 0; i < 4; i++)
            send4(32'hB000_0000 + 32'(i), (i == 3), 4'hF, 1, (i == 3), 1'b0, w);
        idle(3);
        check("exact_count", q_out4.size(), 4);
        check("exact_last", q_out4[3], {1'b1, 32'hB000_0003});
        check("exact_notrunc", n_trunc4, 0);
        check("exact_pktcnt", pkt_cnt4, stat(2));

        // Over-length: 7 beats, forced tlast on beat 3 keeps its partial tkeep
        q_out4.delete(); n_trunc4 = 0;
        for (int i = 0; i < 3; i++)
            send4(32'hC000_0000 + 32'(i), 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        send4(32'hC000_0003, 1'b0, 4'h3, 1, 1'b1, 1'b1, w);
        for (int i = 4; i < 7; i++) begin
            send4(32'hC000_0000 + 32'(i), (i == 6), 4'hF, 0, 1'b0, 1'b0, w);
            check("discard_ready", w, 0);
        end
        send4(32'hD000_0000, 1'b1, 4'hF, 1, 1'b1, 1'b0, w);
        check("next_pkt_nogap", w, 0);
        idle(3);
        check("over_count", q_out4.size(), 5);
        check("over_cut_beat", q_out4[3], {1'b1, 32'hC000_0003});
        check("over_next_beat", q_out4[4], {1'b1, 32'hD000_0000});
        check("over_trunc_pulses", n_trunc4, 1);
        check("over_trunccnt", trunc_cnt4, stat(1));
        check("over_pktcnt", pkt_cnt4, stat(4));

        // Backpressure: downstream stalls with one beat buffered
        q_out4.delete();
        send4(32'hE000_0000, 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        out4.tready = 1'b0;
        in4.tdata = 32'hE000_0001; in4.tlast = 1'b0; in4.tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_in_ready", in4.tready, 1'b0);
            check("bp_hold_valid", out4.tvalid, 1'b1);
            check("bp_hold_data", out4.tdata, 32'hE000_0000);
        end
        @(posedge clk_i);
        #1 out4.tready = 1'b1;
        send4(32'hE000_0001, 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        check("bp_release_wait", w, 0);
        send4(32'hE000_0002, 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        check("bp_rate_e2", w, 0);
        send4(32'hE000_0003, 1'b1, 4'hF, 1, 1'b1, 1'b0, w);
        check("bp_rate_e3", w, 0);
        idle(3);
        check("bp_count", q_out4.size(), 4);
        for (int i = 0; i < 4; i++)
            check("bp_order", q_out4[i], {(i == 3), 32'hE000_0000 + 32'(i)});
        check("bp_pktcnt", pkt_cnt4, stat(5));

        // Reset in the middle of an 8-beat packet
        send4(32'hF000_0000, 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        send4(32'hF000_0001, 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        rst_i = 1'b1;
        #1;
        check("midrst_valid", out4.tvalid, 1'b0);
        check("midrst_data", out4.tdata, 32'h0);
        check("midrst_pktcnt", pkt_cnt4, 32'h0);
        check("midrst_trunccnt", trunc_cnt4, 32'h0);
        idle(2);
        rst_i = 1'b0;
        q_out4.delete(); n_trunc4 = 0;
        for (int i = 0; i < 3; i++)
            send4(32'h6000_0000 + 32'(i), 1'b0, 4'hF, 1, 1'b0, 1'b0, w);
        send4(32'h6000_0003, 1'b0, 4'hF, 1, 1'b1, 1'b1, w);
        send4(32'h6000_0004, 1'b1, 4'hF, 0, 1'b0, 1'b0, w);
        send4(32'h7000_0000, 1'b1, 4'hF, 1, 1'b1, 1'b0, w);
        idle(3);
        check("postrst_count", q_out4.size(), 5);
        check("postrst_cut", q_out4[3], {1'b1, 32'h6000_0003});
        check("postrst_trunc", n_trunc4, 1);
        check("postrst_pktcnt", pkt_cnt4, stat(2));
        check("postrst_trunccnt", trunc_cnt4, stat(1));

        // MAX_WORDS=1 instance
        q_out1.delete(); n_trunc1 = 0;
        send1(32'h1000_0000, 1'b0, 1, 1'b1);
        send1(32'h1000_0001, 1'b0, 0, 1'b0);
        send1(32'h1000_0002, 1'b1, 0, 1'b0);
        send1(32'h1100_0000, 1'b1, 1, 1'b0);
        send1(32'h1200_0000, 1'b0, 1, 1'b1);
        send1(32'h1200_0001, 1'b1, 0, 1'b0);
        idle(3);
        check("mw1_count", q_out1.size(), 3);
        check("mw1_first", q_out1[0], {1'b1, 32'h1000_0000});
        check("mw1_second", q_out1[1], {1'b1, 32'h1100_0000});
        check("mw1_third", q_out1[2], {1'b1, 32'h1200_0000});
        check("mw1_trunc", n_trunc1, 2);
        check("mw1_pktcnt", pkt_cnt1, stat(3));
        check("mw1_trunccnt", trunc_cnt1, stat(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
